// File: rtl/neural_sweep_ctrl_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : neural_sweep_ctrl_if                                       |
// | Brief   : Configuration, aggregator-beat and sweep-status bundle for |
// |           neural_sweep_ctrl. master = controller, slave = host side. |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
interface neural_sweep_ctrl_if #(
   parameter int NUM_CHANNELS = 16,
   parameter int CH_ID_WIDTH  = 4,
   parameter int PERIOD_WIDTH = 16
);
   // configuration from the host
   logic                    cfg_enable;
   logic                    cfg_load;
   logic [NUM_CHANNELS-1:0] cfg_mask;
   logic [PERIOD_WIDTH-1:0] cfg_period;
   // beats returned by the aggregator
   logic                    adc_valid_out;
   logic [CH_ID_WIDTH-1:0]  adc_channel_out;
   // sweep control and status
   logic                    sweep_start;
   logic [NUM_CHANNELS-1:0] sweep_mask;
   logic                    busy;
   logic                    sweep_done;
   logic [15:0]             sweep_count;
   logic [NUM_CHANNELS-1:0] missing_mask;
   logic                    err_missing;
   logic                    err_order;

   modport master (
      input  cfg_enable, cfg_load, cfg_mask, cfg_period,
      input  adc_valid_out, adc_channel_out,
      output sweep_start, sweep_mask, busy, sweep_done, sweep_count,
      output missing_mask, err_missing, err_order
   );

   modport slave (
      output cfg_enable, cfg_load, cfg_mask, cfg_period,
      output adc_valid_out, adc_channel_out,
      input  sweep_start, sweep_mask, busy, sweep_done, sweep_count,
      input  missing_mask, err_missing, err_order
   );
endinterface
`default_nettype wire

// File: rtl/neural_sweep_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : neural_sweep_ctrl                                          |
// | Brief   : Periodic masked sweep scheduler for neural_aggregator.     |
// |           Launches sweeps, tracks returned beats against the active  |
// |           mask, reports completion, missing channels and protocol    |
// |           errors. Config is shadowed and applied on sweep launch.    |
// | Options : STRICT_ORDER_EN - beats must arrive in ascending channel   |
// |           order within a sweep.                                      |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module neural_sweep_ctrl #(
   parameter int NUM_CHANNELS   = 16,
   parameter int CH_ID_WIDTH    = 4,
   parameter int PERIOD_WIDTH   = 16,
   parameter int TIMEOUT_CYCLES = 64
) (
   input  wire logic            sys_clk,
   input  wire logic            rst,
   neural_sweep_ctrl_if.master  bus
);

   localparam int TMO_W = $clog2(TIMEOUT_CYCLES) + 1;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LAUNCH  = 3'd1,
      S_COLLECT = 3'd2,
      S_DONE    = 3'd3,
      S_WAIT    = 3'd4
   } state_t;

   state_t                  state_q, state_d;
   logic [NUM_CHANNELS-1:0] pend_mask_q;
   logic [PERIOD_WIDTH-1:0] pend_period_q;
   logic [NUM_CHANNELS-1:0] act_mask_q, act_mask_d;
   logic [PERIOD_WIDTH-1:0] act_period_q, act_period_d;
   logic [NUM_CHANNELS-1:0] expected_q, expected_d;
   logic [TMO_W-1:0]        tmo_q, tmo_d;
   logic [PERIOD_WIDTH-1:0] wcnt_q, wcnt_d;
   logic                    timeout_q, timeout_d;
   logic [15:0]             count_q, count_d;
   logic                    err_order_q, err_order_d;

   logic [CH_ID_WIDTH-1:0]  w_ch;
   logic [NUM_CHANNELS-1:0] w_beat_onehot;
   logic                    w_hit;
   logic                    w_in_sweep;
   logic                    w_seq_viol;
   logic                    w_launch_entry;
   logic [NUM_CHANNELS-1:0] w_launch_mask;
   logic [PERIOD_WIDTH-1:0] w_launch_period;
   logic [TMO_W-1:0]        w_tmo_inc;
   logic [PERIOD_WIDTH:0]   w_wcnt_inc;

   assign w_ch          = bus.adc_channel_out;
   // out-of-range ids shift the one out and therefore never hit
   assign w_beat_onehot = NUM_CHANNELS'(1) << w_ch;
   assign w_hit         = |(w_beat_onehot & expected_q);
   assign w_in_sweep    = (state_q == S_LAUNCH) || (state_q == S_COLLECT);
   assign w_tmo_inc     = tmo_q + TMO_W'(1);
   assign w_wcnt_inc    = {1'b0, wcnt_q} + (PERIOD_WIDTH+1)'(1);
   // a load coinciding with launch entry is honoured immediately
   assign w_launch_mask   = bus.cfg_load ? bus.cfg_mask   : pend_mask_q;
   assign w_launch_period = bus.cfg_load ? bus.cfg_period : pend_period_q;
   // LAUNCH never persists, so any next-state of LAUNCH is an entry
   assign w_launch_entry  = (state_d == S_LAUNCH) && (state_q != S_LAUNCH);

`ifdef STRICT_ORDER_EN
   logic [CH_ID_WIDTH-1:0] last_ch_q;
   logic                   have_last_q;

   assign w_seq_viol = have_last_q && (w_ch <= last_ch_q);

   // remember the last channel that cleared an expected bit this sweep
   always_ff @(posedge sys_clk) begin
      if (rst || w_launch_entry) begin
         last_ch_q   <= '0;
         have_last_q <= 1'b0;
      end else if (w_in_sweep && bus.adc_valid_out && w_hit) begin
         last_ch_q   <= w_ch;
         have_last_q <= 1'b1;
      end
   end
`else
   assign w_seq_viol = 1'b0;
`endif

   // pending (shadow) configuration, captured on any cfg_load pulse
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         pend_mask_q   <= '0;
         pend_period_q <= '0;
      end else if (bus.cfg_load) begin
         pend_mask_q   <= bus.cfg_mask;
         pend_period_q <= bus.cfg_period;
      end
   end

   // next-state and datapath updates for the sweep FSM
   always_comb begin
      state_d      = state_q;
      act_mask_d   = act_mask_q;
      act_period_d = act_period_q;
      expected_d   = expected_q;
      tmo_d        = tmo_q;
      wcnt_d       = wcnt_q;
      timeout_d    = timeout_q;
      count_d      = count_q;
      err_order_d  = bus.adc_valid_out && (!w_in_sweep || !w_hit || w_seq_viol);

      case (state_q)
         S_IDLE: begin
            if (bus.cfg_enable) state_d = S_LAUNCH;
         end
         S_LAUNCH: begin
            tmo_d = '0;
            if (act_mask_q == '0) begin
               // nothing to sweep: skip straight to the interval wait
               wcnt_d  = '0;
               state_d = bus.cfg_enable ? S_WAIT : S_IDLE;
            end else begin
               if (bus.adc_valid_out && w_hit) expected_d = expected_q & ~w_beat_onehot;
               if (expected_d == '0) begin
                  timeout_d = 1'b0;
                  state_d   = S_DONE;
               end else begin
                  state_d = S_COLLECT;
               end
            end
         end
         S_COLLECT: begin
            if (bus.adc_valid_out) begin
               tmo_d = '0;
               if (w_hit) expected_d = expected_q & ~w_beat_onehot;
            end
            if (expected_d == '0) begin
               timeout_d = 1'b0;
               state_d   = S_DONE;
            end else if (!bus.adc_valid_out) begin
               if (w_tmo_inc == TMO_W'(TIMEOUT_CYCLES-1)) begin
                  timeout_d = 1'b1;
                  state_d   = S_DONE;
               end else begin
                  tmo_d = w_tmo_inc;
               end
            end
         end
         S_DONE: begin
            if (!bus.cfg_enable) begin
               state_d = S_IDLE;
            end else if (act_period_q == '0) begin
               state_d = S_LAUNCH;
            end else begin
               wcnt_d  = '0;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (!bus.cfg_enable) begin
               state_d = S_IDLE;
            end else if (w_wcnt_inc >= {1'b0, act_period_q}) begin
               state_d = S_LAUNCH;
            end else begin
               wcnt_d = w_wcnt_inc[PERIOD_WIDTH-1:0];
            end
         end
         default: state_d = S_IDLE;
      endcase

      // config is latched into the active set only as a sweep is launched
      if (w_launch_entry) begin
         act_mask_d   = w_launch_mask;
         act_period_d = w_launch_period;
         expected_d   = w_launch_mask;
         tmo_d        = '0;
      end

      if ((state_d == S_DONE) && (state_q != S_DONE)) count_d = count_q + 16'd1;
   end

   // state and datapath registers
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state_q      <= S_IDLE;
         act_mask_q   <= '0;
         act_period_q <= '0;
         expected_q   <= '0;
         tmo_q        <= '0;
         wcnt_q       <= '0;
         timeout_q    <= 1'b0;
         count_q      <= '0;
         err_order_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         act_mask_q   <= act_mask_d;
         act_period_q <= act_period_d;
         expected_q   <= expected_d;
         tmo_q        <= tmo_d;
         wcnt_q       <= wcnt_d;
         timeout_q    <= timeout_d;
         count_q      <= count_d;
         err_order_q  <= err_order_d;
      end
   end

   // a zero-mask launch issues no sweep and is not reported as busy
   assign bus.sweep_start  = (state_q == S_LAUNCH) && (act_mask_q != '0);
   assign bus.busy         = bus.sweep_start || (state_q == S_COLLECT);
   assign bus.sweep_done   = (state_q == S_DONE);
   assign bus.sweep_mask   = act_mask_q;
   assign bus.sweep_count  = count_q;
   assign bus.missing_mask = (state_q == S_DONE) ? expected_q : '0;
   assign bus.err_missing  = (state_q == S_DONE) && timeout_q;
   assign bus.err_order    = err_order_q;

endmodule
`default_nettype wire

// File: tb/tb_neural_sweep_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_neural_sweep_ctrl                                       |
// | Brief   : Scoreboard bench for neural_sweep_ctrl. Stimulus pushes    |
// |           expected start/done/err_order events; a negedge monitor    |
// |           pops and compares them as the DUT presents them.           |
// | Options : STRICT_ORDER_EN changes the expected result of the last    |
// |           ordering test.                                             |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_neural_sweep_ctrl;

   localparam int NCH = 16;
   localparam int CHW = 4;
   localparam int PW  = 16;
   localparam int TMO = 64;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   neural_sweep_ctrl_if #(.NUM_CHANNELS(NCH), .CH_ID_WIDTH(CHW), .PERIOD_WIDTH(PW)) bus ();

   neural_sweep_ctrl #(
      .NUM_CHANNELS(NCH), .CH_ID_WIDTH(CHW), .PERIOD_WIDTH(PW), .TIMEOUT_CYCLES(TMO)
   ) dut (
      .sys_clk (clk),
      .rst     (rst),
      .bus     (bus)
   );

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int          cyc;
      logic [15:0] mask;
      logic [15:0] miss;
      logic [15:0] cnt;
      logic        errm;
   } ev_t;

   ev_t q_start[$];
   ev_t q_done[$];
   ev_t q_err[$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic void exp_start(input int c, input logic [15:0] m);
      ev_t e;
      e = '{cyc: c, mask: m, miss: 16'h0, cnt: 16'h0, errm: 1'b0};
      q_start.push_back(e);
   endfunction

   function automatic void exp_done(input int c, input logic [15:0] miss,
                                    input logic [15:0] m, input logic [15:0] cnt,
                                    input logic errm);
      ev_t e;
      e = '{cyc: c, mask: m, miss: miss, cnt: cnt, errm: errm};
      q_done.push_back(e);
   endfunction

   function automatic void exp_err(input int c);
      ev_t e;
      e = '{cyc: c, mask: 16'h0, miss: 16'h0, cnt: 16'h0, errm: 1'b0};
      q_err.push_back(e);
   endfunction

   // monitor: compare every presented event against the head of its queue
   always @(negedge clk) begin
      ev_t e;
      if (bus.sweep_start === 1'b1) begin
         if (q_start.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_start: got sweep_start at cycle %0d, want none", cyc);
         end else begin
            e = q_start.pop_front();
            chk("start_cycle", 32'(cyc), 32'(e.cyc));
            chk("start_mask", 32'(bus.sweep_mask), 32'(e.mask));
         end
      end
      if (bus.sweep_done === 1'b1) begin
         if (q_done.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_done: got sweep_done at cycle %0d, want none", cyc);
         end else begin
            e = q_done.pop_front();
            chk("done_cycle", 32'(cyc), 32'(e.cyc));
            chk("done_missing", 32'(bus.missing_mask), 32'(e.miss));
            chk("done_sweep_mask", 32'(bus.sweep_mask), 32'(e.mask));
            chk("done_count", 32'(bus.sweep_count), 32'(e.cnt));
            chk("done_err_missing", 32'(bus.err_missing), 32'(e.errm));
         end
      end
      if (bus.err_order === 1'b1) begin
         if (q_err.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_err_order: got err_order at cycle %0d, want none", cyc);
         end else begin
            e = q_err.pop_front();
            chk("err_order_cycle", 32'(cyc), 32'(e.cyc));
         end
      end
   end

   task automatic goto_cycle(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic beat(input int ch);
      bus.adc_valid_out   = 1'b1;
      bus.adc_channel_out = CHW'(ch);
   endtask

   task automatic no_beat();
      bus.adc_valid_out = 1'b0;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_start"},   32'(bus.sweep_start),  32'h0);
      chk({tag, "_busy"},    32'(bus.busy),         32'h0);
      chk({tag, "_done"},    32'(bus.sweep_done),   32'h0);
      chk({tag, "_mask"},    32'(bus.sweep_mask),   32'h0);
      chk({tag, "_count"},   32'(bus.sweep_count),  32'h0);
      chk({tag, "_missing"}, 32'(bus.missing_mask), 32'h0);
      chk({tag, "_errm"},    32'(bus.err_missing),  32'h0);
      chk({tag, "_erro"},    32'(bus.err_order),    32'h0);
   endtask

   initial begin
      int t, l3, l4, l5, l6, busy_hits;
      ev_t e;
      rst = 1'b1;
      bus.cfg_enable = 1'b0; bus.cfg_load = 1'b0;
      bus.cfg_mask = '0; bus.cfg_period = '0;
      bus.adc_valid_out = 1'b0; bus.adc_channel_out = '0;

      goto_cycle(3);
      chk_all_zero("reset");
      rst = 1'b0;
      goto_cycle(5);

      // mask 0x0005, period 10; ch0 then ch2
      t = cyc;
      bus.cfg_enable = 1'b1; bus.cfg_load = 1'b1;
      bus.cfg_mask = 16'h0005; bus.cfg_period = 16'd10;
      exp_start(t + 1, 16'h0005);
      goto_cycle(t + 1); bus.cfg_load = 1'b0;
      chk("busy_launch", 32'(bus.busy), 32'h1);
      goto_cycle(t + 3); beat(0);
      goto_cycle(t + 4); no_beat();
      goto_cycle(t + 5); beat(2);
      exp_done(t + 6, 16'h0000, 16'h0005, 16'd1, 1'b0);
      exp_start(t + 17, 16'h0005);
      goto_cycle(t + 6); no_beat();

      // second sweep: beat in the LAUNCH cycle belongs to the sweep
      goto_cycle(t + 17); beat(0);
      goto_cycle(t + 18); beat(2);
      exp_done(t + 19, 16'h0000, 16'h0005, 16'd2, 1'b0);
      l3 = t + 30;
      exp_start(l3, 16'h0005);
      goto_cycle(t + 19); no_beat();

      // third sweep: unmasked ch3, ch0, duplicate ch0, then ch2; reload mid-sweep
      goto_cycle(l3 + 1);
      bus.cfg_load = 1'b1; bus.cfg_mask = 16'h0003; bus.cfg_period = 16'd0;
      goto_cycle(l3 + 2); bus.cfg_load = 1'b0; beat(3); exp_err(l3 + 3);
      goto_cycle(l3 + 3); beat(0);
      goto_cycle(l3 + 4); beat(0); exp_err(l3 + 5);
      goto_cycle(l3 + 5); no_beat();
      goto_cycle(l3 + 7); beat(2);
      exp_done(l3 + 8, 16'h0000, 16'h0005, 16'd3, 1'b0);
      l4 = l3 + 19;
      exp_start(l4, 16'h0003);
      goto_cycle(l3 + 8); no_beat();

      // fourth sweep (0x0003, period 0): load 0xFFFF during COLLECT
      goto_cycle(l4 + 1);
      bus.cfg_load = 1'b1; bus.cfg_mask = 16'hFFFF;
      goto_cycle(l4 + 2); bus.cfg_load = 1'b0; beat(0);
      goto_cycle(l4 + 3); beat(1);
      exp_done(l4 + 4, 16'h0000, 16'h0003, 16'd4, 1'b0);
      l5 = l4 + 5;
      exp_start(l5, 16'hFFFF);
      goto_cycle(l4 + 4); no_beat();

      // fifth sweep (0xFFFF): no beats at all, times out
      goto_cycle(l5 + 1);
      bus.cfg_load = 1'b1; bus.cfg_mask = 16'h00F0; bus.cfg_period = 16'd3;
      exp_done(l5 + 64, 16'hFFFF, 16'hFFFF, 16'd5, 1'b1);
      l6 = l5 + 65;
      exp_start(l6, 16'h00F0);
      goto_cycle(l5 + 2); bus.cfg_load = 1'b0;

      // sixth sweep (0x00F0): only ch4, ch5 -> timeout 64 cycles after ch5
      goto_cycle(l6 + 1); beat(4);
      goto_cycle(l6 + 2); no_beat();
      goto_cycle(l6 + 3); beat(5);
      exp_done(l6 + 67, 16'h00C0, 16'h00F0, 16'd6, 1'b1);
      goto_cycle(l6 + 4); no_beat();
      goto_cycle(l6 + 5); bus.cfg_enable = 1'b0;
      goto_cycle(l6 + 68);
      chk("busy_idle", 32'(bus.busy), 32'h0);

      // beat while IDLE is a protocol error
      goto_cycle(l6 + 88);
      t = cyc; beat(1); exp_err(t + 1);
      goto_cycle(t + 1); no_beat();
      goto_cycle(t + 3);
      chk("count_idle", 32'(bus.sweep_count), 32'd6);

      // zero mask for 100 cycles: never busy, never starts, count unchanged
      bus.cfg_load = 1'b1; bus.cfg_mask = 16'h0000; bus.cfg_period = 16'd2;
      bus.cfg_enable = 1'b1;
      t = cyc;
      goto_cycle(t + 1); bus.cfg_load = 1'b0;
      busy_hits = 0;
      for (int i = 0; i < 100; i++) begin
         goto_cycle(t + 2 + i);
         if (bus.busy) busy_hits++;
      end
      chk("busy_mask0", 32'(busy_hits), 32'd0);
      chk("count_mask0", 32'(bus.sweep_count), 32'd6);
      bus.cfg_enable = 1'b0;
      goto_cycle(cyc + 3);

      // reset during COLLECT
      t = cyc;
      bus.cfg_load = 1'b1; bus.cfg_mask = 16'h0003; bus.cfg_period = 16'd0;
      bus.cfg_enable = 1'b1;
      exp_start(t + 1, 16'h0003);
      goto_cycle(t + 1); bus.cfg_load = 1'b0;
      goto_cycle(t + 2); rst = 1'b1;
      goto_cycle(t + 3);
      chk_all_zero("midrst");
      rst = 1'b0;
      // shadow mask was cleared by reset, so enabling must not launch a sweep
      goto_cycle(t + 13);
      chk("count_after_rst", 32'(bus.sweep_count), 32'd0);
      bus.cfg_enable = 1'b0;
      goto_cycle(t + 16);

      // ch2 then ch0: order error only with strict ordering
      t = cyc;
      bus.cfg_load = 1'b1; bus.cfg_mask = 16'h0005; bus.cfg_period = 16'd0;
      bus.cfg_enable = 1'b1;
      exp_start(t + 1, 16'h0005);
      goto_cycle(t + 1); bus.cfg_load = 1'b0;
      goto_cycle(t + 2); beat(2);
      goto_cycle(t + 3); beat(0); bus.cfg_enable = 1'b0;
      exp_done(t + 4, 16'h0000, 16'h0005, 16'd1, 1'b0);
`ifdef STRICT_ORDER_EN
      exp_err(t + 4);
`endif
      goto_cycle(t + 4); no_beat();
      goto_cycle(t + 14);

      // every expected event must have been consumed
      while (q_start.size() > 0) begin
         e = q_start.pop_front(); checks++; errors++;
         $display("FAIL missing_start: got none, want sweep_start at cycle %0d", e.cyc);
      end
      while (q_done.size() > 0) begin
         e = q_done.pop_front(); checks++; errors++;
         $display("FAIL missing_done: got none, want sweep_done at cycle %0d", e.cyc);
      end
      while (q_err.size() > 0) begin
         e = q_err.pop_front(); checks++; errors++;
         $display("FAIL missing_err_order: got none, want err_order at cycle %0d", e.cyc);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
